// File: rtl/frame_seq_ctrl.sv
// Frame buffer sequencer: loads a frame into BRAM, computes its mean, then streams it out.
// Optional build macro THRESH_EN binarizes the output stream against the frame mean.
module frame_seq_ctrl #(
    parameter int unsigned LOG2_SIZE = 6,
    parameter int unsigned ADDR_W    = 2 * LOG2_SIZE,
    parameter int unsigned SUM_W     = 8 + 2 * LOG2_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic [7:0]        thresh,
    output logic [2:0]        state,
    output logic              frame_done,
    output logic              rx_overrun
);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_MEAN = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_TX   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            cur;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [SUM_W-1:0]  sum;
    logic [7:0]        pix_out;

    assign state = cur;

    always_comb begin
`ifdef THRESH_EN
        pix_out = (rd_data > thresh) ? 8'hFF : 8'h00;
`else
        pix_out = rd_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur        <= S_LOAD;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            sum        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            thresh     <= '0;
            frame_done <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            frame_done <= 1'b0;
            if (rx_valid && cur != S_LOAD)
                rx_overrun <= 1'b1;

            case (cur)
                S_LOAD: begin
                    if (rx_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= wr_cnt;
                        wr_data <= rx_data;
                        sum     <= sum + SUM_W'(rx_data);
                        wr_cnt  <= wr_cnt + ADDR_W'(1);
                        if (wr_cnt == LAST)
                            cur <= S_MEAN;
                    end
                end
                // Read strobe is registered on entry so it is high during the RD cycle itself.
                S_MEAN: begin
                    thresh  <= sum[SUM_W-1:ADDR_W];
                    rd_en   <= 1'b1;
                    rd_addr <= rd_cnt;
                    cur     <= S_RD;
                end
                S_RD: begin
                    cur <= S_WAIT;
                end
                S_WAIT: begin
                    tx_data  <= pix_out;
                    tx_valid <= 1'b1;
                    cur      <= S_TX;
                end
                S_TX: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (rd_cnt == LAST) begin
                            frame_done <= 1'b1;
                            cur        <= S_DONE;
                        end else begin
                            rd_cnt  <= rd_cnt + ADDR_W'(1);
                            rd_en   <= 1'b1;
                            rd_addr <= rd_cnt + ADDR_W'(1);
                            cur     <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    sum    <= '0;
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                    cur    <= S_LOAD;
                end
                default: cur <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl at a 4x4 frame; expectations follow the THRESH_EN build setting.
module tb_frame_seq_ctrl;

    localparam int unsigned LOG2 = 2;
    localparam int unsigned AW   = 2 * LOG2;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          tx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [7:0]    thresh;
    logic [2:0]    state;
    logic          frame_done;
    logic          rx_overrun;

    frame_seq_ctrl #(.LOG2_SIZE(LOG2), .ADDR_W(AW), .SUM_W(8 + AW)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .thresh(thresh), .state(state), .frame_done(frame_done), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    // Dual-port BRAM model, 1-cycle read latency
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int vectors    = 0;
    int miscompares = 0;
    int wr_q[$];
    int tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write pulse and every tx transfer
    always @(negedge clk) begin
        int e;
        if (reset === 1'b1) begin
            if (wr_en) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr), e >> 8);
                    check("wr_data", 32'(wr_data), e & 255);
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
                else begin
                    e = tx_q.pop_front();
                    check("tx_data", 32'(tx_data), e);
                end
            end
        end
    end

    int pix_a[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int pix_b[16] = '{10, 200, 10, 200, 10, 200, 10, 200, 10, 200, 10, 200, 10, 200, 10, 200};
    int pix_c[16] = '{16{100}};
`ifdef THRESH_EN
    int exp_a[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 255, 255, 255, 255, 255, 255, 255, 255};
    int exp_b[16] = '{0, 255, 0, 255, 0, 255, 0, 255, 0, 255, 0, 255, 0, 255, 0, 255};
    int exp_c[16] = '{16{0}};
`else
    int exp_a[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int exp_b[16] = '{10, 200, 10, 200, 10, 200, 10, 200, 10, 200, 10, 200, 10, 200, 10, 200};
    int exp_c[16] = '{16{100}};
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input int p, input int addr);
        wr_q.push_back(addr * 256 + p);
        rx_valid = 1'b1;
        rx_data  = 8'(p);
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_done_seen", 32'(seen), 1);
        if (seen) begin
            check("done_state", 32'(state), 5);
            @(negedge clk);
            check("done_pulse_width", 32'(frame_done), 0);
            check("state_after_done", 32'(state), 0);
        end
        check("tx_queue_drained", tx_q.size(), 0);
    endtask

    task automatic run_frame(input int pix[16], input int exp[16], input int thr,
                             input bit stall, input bit inject);
        bit found;
        for (int i = 0; i < 16; i++) tx_q.push_back(exp[i]);
        if (stall) tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_pixel(pix[i], i);
        if (stall) begin
            found = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (tx_valid) begin found = 1'b1; break; end
            end
            check("stall_tx_valid_seen", 32'(found), 1);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                check("stall_tx_valid", 32'(tx_valid), 1);
                check("stall_tx_data", 32'(tx_data), exp[0]);
                check("stall_rd_en", 32'(rd_en), 0);
            end
            tick();
            tx_ready = 1'b1;
        end
        if (inject) begin
            found = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (state == 3'd2) begin found = 1'b1; break; end
            end
            check("inject_rd_seen", 32'(found), 1);
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            @(negedge clk);
            check("rx_overrun_set", 32'(rx_overrun), 1);
        end
        wait_done();
        check("thresh", 32'(thresh), thr);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_state", 32'(state), 0);
        check("rst_thresh", 32'(thresh), 0);
        tick();
        reset = 1'b1;
        tick();

        // Ramp frame with a 20-cycle tx_ready stall on the first byte
        run_frame(pix_a, exp_a, 7, 1'b1, 1'b0);
        check("no_overrun_yet", 32'(rx_overrun), 0);

        // Alternating frame with a stray byte during RD
        run_frame(pix_b, exp_b, 105, 1'b0, 1'b1);
        check("overrun_sticky", 32'(rx_overrun), 1);

        // Partial frame then reset: five pixels written, then discarded
        for (int i = 0; i < 5; i++) send_pixel(50, i);
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_state", 32'(state), 0);
        check("midrst_thresh", 32'(thresh), 0);
        check("midrst_overrun", 32'(rx_overrun), 0);
        check("midrst_wr_en", 32'(wr_en), 0);
        check("midrst_wr_addr", 32'(wr_addr), 0);
        check("midrst_tx_data", 32'(tx_data), 0);
        check("midrst_frame_done", 32'(frame_done), 0);
        tick();
        reset = 1'b1;
        tick();

        // Flat frame: mean equals every pixel, so strict compare gives all zeros
        run_frame(pix_c, exp_c, 100, 1'b0, 1'b0);
        check("final_overrun", 32'(rx_overrun), 0);
        check("wr_queue_drained", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
